// File: rtl/datapath_pkg.sv
// Shared datapath definitions: widths, shifter FSM encoding and ALU shift-mode selects.
package datapath_pkg;

    localparam int DATA_W  = 16;
    localparam int SHAMT_W = 4;

    localparam logic SHIFT_LOGICAL = 1'b0;
    localparam logic SHIFT_ARITH   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } shift_state_t;

endpackage

// File: rtl/serial_shift_right.sv
// Multi-cycle right shifter (one bit per clock, logical or arithmetic) with start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | shifting one bit per cycle, count holds remaining steps
// DONE  | result on data_out, done pulse; start here is accepted immediately
module serial_shift_right
    import datapath_pkg::*;
#(
    parameter int WIDTH   = datapath_pkg::DATA_W,
    parameter int SHAMT_W = datapath_pkg::SHAMT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   data_out
);

    shift_state_t       state_q, state_d;
    logic [WIDTH-1:0]   work_q;
    logic [SHAMT_W-1:0] count_q;
    logic               fill_q;
    logic               load;
    logic               shift_en;
    logic               last_step;
    logic [WIDTH-1:0]   shifted;

    assign shifted   = {fill_q, work_q[WIDTH-1:1]};
    assign last_step = (count_q == SHAMT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        shift_en = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (start) begin
                    load    = 1'b1;
                    state_d = (shamt == '0) ? DONE : SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                if (last_step) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // data_out is only written on entry to DONE, so partial shifts never leak out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q   <= '0;
            count_q  <= '0;
            fill_q   <= 1'b0;
            data_out <= '0;
        end else if (load) begin
            work_q  <= data_in;
            count_q <= shamt;
            fill_q  <= arith & data_in[WIDTH-1];
            if (shamt == '0) begin
                data_out <= data_in;
            end
        end else if (shift_en) begin
            work_q  <= shifted;
            count_q <= count_q - SHAMT_W'(1);
            if (last_step) begin
                data_out <= shifted;
            end
        end
    end

endmodule

// File: tb/tb_serial_shift_right.sv
// Directed scoreboard bench for serial_shift_right.
module tb_serial_shift_right;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] data_in;
    logic [3:0]  shamt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [15:0] data_out;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [15:0] data;
        int          lat;
    } exp_t;

    exp_t sb[$];

    serial_shift_right #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .data_in  (data_in),
        .shamt    (shamt),
        .arith    (arith),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] d, input logic [3:0] s, input logic a);
        logic signed [15:0] sd;
        sd = d;
        if (a) return sd >>> s;
        return d >> s;
    endfunction

    always @(negedge clk) begin
        if (rst_n) check("busy_and_done", {31'd0, busy & done}, 32'd0);
    end

    task automatic push_exp(input logic [15:0] d, input logic [3:0] s, input logic a);
        exp_t e;
        e.data = model(d, s, a);
        e.lat  = int'(s) + 1;
        sb.push_back(e);
    endtask

    // Wait for done from the current negedge; cyc counts edges since the accepting edge.
    task automatic wait_done(input int cyc0, input logic [15:0] held, input int inject_at, output int cyc);
        cyc = cyc0;
        while (!done && cyc < 40) begin
            check("busy_while_shift", {31'd0, busy}, 32'd1);
            check("out_held", {16'd0, data_out}, {16'd0, held});
            if (cyc == inject_at) begin
                start = 1'b1; data_in = 16'h5A5A; shamt = 4'd2; arith = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic compare_done(input int cyc);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check("done_seen", {31'd0, done}, 32'd1);
        check("latency", cyc, e.lat);
        check("data_out", {16'd0, data_out}, {16'd0, e.data});
    endtask

    task automatic run_op(input logic [15:0] d, input logic [3:0] s, input logic a, input int inject_at);
        int cyc;
        logic [15:0] held;
        logic [15:0] want;
        held = data_out;
        want = model(d, s, a);
        push_exp(d, s, a);
        data_in = d; shamt = s; arith = a; start = 1'b1;
        @(negedge clk);
        start = 1'b0; data_in = 16'hFFFF; shamt = 4'hF; arith = 1'b1;
        wait_done(1, held, inject_at, cyc);
        compare_done(cyc);
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd0);
        check("result_held", {16'd0, data_out}, {16'd0, want});
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; start = 1'b0; data_in = '0; shamt = '0; arith = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_out", {16'd0, data_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(16'h1A36, 4'd1, 1'b0, -1);
        run_op(16'hF000, 4'd4, 1'b1, -1);
        run_op(16'hF000, 4'd4, 1'b0, -1);
        run_op(16'hBEEF, 4'd0, 1'b0, -1);
        run_op(16'h8000, 4'd15, 1'b1, -1);
        run_op(16'h7FFF, 4'd15, 1'b1, -1);
        run_op(16'h1234, 4'd8, 1'b0, 3);
        run_op(16'hC3A5, 4'd7, 1'b1, 2);

        // start held high through SHIFT and into DONE: second op accepted from DONE
        data_in = 16'h00F0; shamt = 4'd3; arith = 1'b0; start = 1'b1;
        push_exp(16'h00F0, 4'd3, 1'b0);
        @(negedge clk);
        data_in = 16'h8421; shamt = 4'd2; arith = 1'b1;
        cyc = 1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        compare_done(cyc);
        push_exp(16'h8421, 4'd2, 1'b1);
        @(negedge clk);
        start = 1'b0;
        check("b2b_done_pulse", {31'd0, done}, 32'd0);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done(1, 16'h001E, -1, cyc);
        compare_done(cyc);
        @(negedge clk);
        check("b2b_done_pulse2", {31'd0, done}, 32'd0);

        // reset in the middle of a shift
        data_in = 16'h1234; shamt = 4'd8; arith = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_out", {16'd0, data_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("no_done_after_rst", {31'd0, done}, 32'd0);
        end

        run_op(16'h0F0F, 4'd2, 1'b1, -1);
        check("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
